gray_counter: RTL and testbench
===============================

Name: gray_counter

Overview:
- Parametrised, registered Gray-code counter. Successor to the combinational binary-to-Gray converter.
- Keeps a binary count internally and presents both the binary and the Gray form, registered.
- Supports up/down counting, synchronous load in binary or Gray format, and a wrap pulse.
- Used as a pointer/sequence generator wherever single-bit-change codes are needed, such as async FIFO pointers and encoders.

Parameters:
- WIDTH, 8, counter and code width in bits (legal range 2..32).
- RESET_VAL, 0, binary value the counter takes at reset (must fit in WIDTH).

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load strobe; has priority over en.
- load_gray  input  1  format of load_val: 1 = Gray, 0 = binary.
- load_val  input  WIDTH  value to load.
- bin_out  output  WIDTH  current count, binary.
- gray_out  output  WIDTH  current count, Gray (bin ^ (bin >> 1)).
- wrap  output  1  one-cycle pulse: the last count step crossed the max/zero boundary.

Behaviour:
- One clock domain, clk. Reset is asynchronous, active-low (rst_n).
- Reset values:
  - bin_out = RESET_VAL
  - gray_out = RESET_VAL ^ (RESET_VAL >> 1)
  - wrap = 0
- Reset is applied immediately on rst_n low, independent of clk. Release is synchronous to the next rising clk edge. Reset asserted mid-count discards all state.
- Per-edge priority: load > en > hold.
- Load:
  - If load_gray=0, the next binary value is load_val.
  - If load_gray=1, load_val is converted Gray-to-binary first: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i], down to bit 0.
  - Both outputs update on the same edge.
  - wrap = 0 on a load cycle, even if en is also high.
- Count (en=1, load=0):
  - up=1: bin_next = bin + 1, modulo 2^WIDTH.
  - up=0: bin_next = bin - 1, modulo 2^WIDTH.
- Hold (en=0, load=0): outputs unchanged; wrap = 0.
- Latency: one cycle from input to outputs. Both outputs come from flops and change together; no combinational input-to-output path.
- gray_out is computed from bin_next and registered, so it is always the Gray form of bin_out in the same cycle.
- Gray property: consecutive counted values of gray_out differ in exactly one bit, including across the wrap boundary.
- wrap is registered. It is 1 in the cycle after an edge where:
  - up=1 and bin was 2^WIDTH-1 (goes to 0), or
  - up=0 and bin was 0 (goes to 2^WIDTH-1).
  - It is 0 otherwise.
- Direction may change on any cycle; the step uses the value of up sampled at that edge.

Optional Feature:
- Macro: GRAY_COUNTER_SAT_EN.
- Defined (saturating mode):
  - Counting up at 2^WIDTH-1 or down at 0 holds the value.
  - wrap is instead asserted for one cycle as a "saturated" indication each edge a step is blocked.
  - Load behaviour is unchanged.
- Undefined: modulo wrap-around exactly as described under Behaviour.

Test Plan (WIDTH=8, RESET_VAL=0):
- Reset: rst_n low mid-count with clk stopped -> bin_out=0x00, gray_out=0x00, wrap=0 immediately.
- Binary load then hold:
  - Load 0x31 (load_gray=0) -> next cycle bin_out=0x31, gray_out=0x29.
  - Load 0xAB -> bin_out=0xAB, gray_out=0xFE.
  - en=0 -> values unchanged.
- Gray load: load_val=0x80 with load_gray=1 -> bin_out=0xFF, gray_out=0x80.
  - Then en=1, up=1 -> bin_out=0x00, gray_out=0x00, wrap=1 for exactly one cycle.
  - (With GRAY_COUNTER_SAT_EN: bin_out stays 0xFF, wrap=1.)
- Down count from 0: en=1, up=0 -> bin_out=0xFF, gray_out=0x80, wrap=1. Next step -> 0xFE/0x81, wrap=0.
- Free-run 256 up steps from 0x00:
  - Every gray_out transition has Hamming distance 1.
  - gray_out == bin_out ^ (bin_out >> 1) every cycle.
  - Exactly one wrap pulse.
- Priority: load=1 with en=1, load_val=0x10 -> bin_out=0x10 (not 0x11), wrap=0.

Source files
------------

// File: rtl/gray_counter_if.sv
// Control and result bundle for gray_counter: the master drives the strobes and
// the load value, and the slave (the counter) returns the binary count, the Gray count and wrap.
interface gray_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             up;
    logic             load;
    logic             load_gray;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] gray_out;
    logic             wrap;

    modport master (
        output en, up, load, load_gray, load_val,
        input  bin_out, gray_out, wrap
    );

    modport slave (
        input  en, up, load, load_gray, load_val,
        output bin_out, gray_out, wrap
    );
endinterface

// File: rtl/gray_counter.sv
// Registered up/down Gray-code counter with binary/Gray load and a wrap pulse.
// Define GRAY_COUNTER_SAT_EN to saturate at the ends; wrap then flags each blocked step.
module gray_counter #(
    parameter int          WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0
) (
    input logic         clk,
    input logic         rst_n,
    gray_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic [WIDTH-1:0] RST_BIN  = RESET_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

    logic [WIDTH-1:0] bin_p1;
    logic [WIDTH-1:0] gray_p1;
    logic             wrap_p1;
    logic [WIDTH-1:0] bin_next;
    logic             wrap_next;

    function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Returns {boundary_hit, next_value}; in saturating mode the value holds at the boundary.
    function automatic logic [WIDTH:0] count_step(input logic [WIDTH-1:0] b, input logic dir);
        logic             at_edge;
        logic [WIDTH-1:0] nxt;
        at_edge = dir ? (b == MAX_VAL) : (b == '0);
        nxt     = dir ? (b + 1'b1) : (b - 1'b1);
`ifdef GRAY_COUNTER_SAT_EN
        if (at_edge) begin
            nxt = b;
        end
`endif
        return {at_edge, nxt};
    endfunction

    always_comb begin
        bin_next  = bin_p1;
        wrap_next = 1'b0;
        if (bus.load) begin
            bin_next = bus.load_gray ? gray_to_bin(bus.load_val) : bus.load_val;
        end else if (bus.en) begin
            {wrap_next, bin_next} = count_step(bin_p1, bus.up);
        end
    end

    // Stage p1: both code forms derive from the same next value and register together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_p1  <= RST_BIN;
            gray_p1 <= RST_GRAY;
            wrap_p1 <= 1'b0;
        end else begin
            bin_p1  <= bin_next;
            gray_p1 <= bin_to_gray(bin_next);
            wrap_p1 <= wrap_next;
        end
    end

    assign bus.bin_out  = bin_p1;
    assign bus.gray_out = gray_p1;
    assign bus.wrap     = wrap_p1;
endmodule

// File: tb/tb_gray_counter.sv
// Randomized bench for gray_counter (WIDTH=8, RESET_VAL=0) against an arithmetic model.
module tb_gray_counter;
    localparam int          W = 8;
    localparam int unsigned M = 256;

    logic clk;
    logic rst_n;
    bit   clk_run;

    int n_total = 0;
    int n_pass  = 0;

    int unsigned m_bin;
    bit          m_wrap;

    gray_counter_if #(.WIDTH(W)) bus ();

    gray_counter #(.WIDTH(W), .RESET_VAL(0)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    function automatic int unsigned to_gray(input int unsigned b);
        return b ^ (b >> 1);
    endfunction

    // Inverse by exhaustive search over the code space.
    function automatic int unsigned from_gray(input int unsigned g);
        for (int unsigned b = 0; b < M; b++) begin
            if (to_gray(b) == g) return b;
        end
        return 0;
    endfunction

    task automatic drive(input bit l, input bit lg, input int unsigned lv, input bit e, input bit u);
        bus.load      = l;
        bus.load_gray = lg;
        bus.load_val  = lv[W-1:0];
        bus.en        = e;
        bus.up        = u;
    endtask

    task automatic model_step();
        if (bus.load) begin
            m_bin  = bus.load_gray ? from_gray(bus.load_val) : bus.load_val;
            m_wrap = 0;
        end else if (bus.en) begin
            if (bus.up) begin
                m_wrap = (m_bin == M - 1);
`ifdef GRAY_COUNTER_SAT_EN
                if (!m_wrap) m_bin = m_bin + 1;
`else
                m_bin = (m_bin + 1) % M;
`endif
            end else begin
                m_wrap = (m_bin == 0);
`ifdef GRAY_COUNTER_SAT_EN
                if (!m_wrap) m_bin = m_bin - 1;
`else
                m_bin = (m_bin + M - 1) % M;
`endif
            end
        end else begin
            m_wrap = 0;
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check({tag, "_bin"},  32'(bus.bin_out),  m_bin);
        check({tag, "_gray"}, 32'(bus.gray_out), to_gray(m_bin));
        check({tag, "_wrap"}, 32'(bus.wrap),     32'(m_wrap));
    endtask

    initial begin
        int wraps;
        logic [W-1:0] prev_gray;
        int unsigned prev_bin;

        clk_run = 1;
        rst_n   = 1'b0;
        drive(0, 0, 0, 0, 1);
        m_bin  = 0;
        m_wrap = 0;
        #1;
        check("rst_bin",  32'(bus.bin_out),  0);
        check("rst_gray", 32'(bus.gray_out), 0);
        check("rst_wrap", 32'(bus.wrap),     0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        drive(1, 0, 'h31, 0, 1); tick("ld31");
        check("ld31_const_bin", 32'(bus.bin_out), 'h31);
        check("ld31_const_gray", 32'(bus.gray_out), 'h29);
        drive(1, 0, 'hAB, 0, 1); tick("ldAB");
        check("ldAB_const_gray", 32'(bus.gray_out), 'hFE);
        drive(0, 0, 0, 0, 1); tick("hold1"); tick("hold2");
        check("hold_const_bin", 32'(bus.bin_out), 'hAB);

        drive(1, 1, 'h80, 0, 1); tick("gld80");
        check("gld80_const_bin", 32'(bus.bin_out), 'hFF);
        drive(0, 0, 0, 1, 1); tick("up_wrap");
`ifdef GRAY_COUNTER_SAT_EN
        check("up_wrap_const_bin", 32'(bus.bin_out), 'hFF);
`else
        check("up_wrap_const_bin", 32'(bus.bin_out), 'h00);
`endif
        check("up_wrap_const_wrap", 32'(bus.wrap), 1);
        drive(0, 0, 0, 0, 1); tick("wrap_clear");

        drive(1, 0, 0, 0, 0); tick("ld0");
        drive(0, 0, 0, 1, 0); tick("dn1");
`ifdef GRAY_COUNTER_SAT_EN
        check("dn1_const_bin", 32'(bus.bin_out), 'h00);
`else
        check("dn1_const_gray", 32'(bus.gray_out), 'h80);
`endif
        tick("dn2");

        drive(1, 0, 'h10, 1, 1); tick("prio");
        check("prio_const_bin", 32'(bus.bin_out), 'h10);

        drive(1, 0, 0, 0, 1); tick("fr_ld");
        drive(0, 0, 0, 1, 1);
        wraps = 0;
        for (int i = 0; i < 256; i++) begin
            prev_gray = bus.gray_out;
            prev_bin  = m_bin;
            tick("fr");
            if (bus.wrap) wraps++;
            if (m_bin != prev_bin) check("fr_ham", $countones(prev_gray ^ bus.gray_out), 1);
        end
        check("fr_wraps", wraps, 1);

        for (int i = 0; i < 300; i++) begin
            int unsigned lv;
            lv = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? M - 1 : 0) : $urandom_range(0, M - 1);
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 1), lv, $urandom_range(0, 3) != 0, $urandom_range(0, 1));
            tick("rnd");
        end

        drive(1, 0, 'h5A, 0, 1); tick("pre_rst");
        drive(0, 0, 0, 1, 1); tick("pre_rst_cnt");
        @(negedge clk);
        clk_run = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_bin",  32'(bus.bin_out),  0);
        check("midrst_gray", 32'(bus.gray_out), 0);
        check("midrst_wrap", 32'(bus.wrap),     0);
        m_bin  = 0;
        m_wrap = 0;
        #5;
        rst_n = 1'b1;
        #2;
        clk_run = 1;
        tick("post_rst1");
        tick("post_rst2");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
